// File: rtl/leb128_fetch_pkg.sv
`default_nettype none
// ============================================================================
// leb128_fetch_pkg : error codes, size limits and FSM encoding for the
//                    LEB128 immediate fetcher (also used by the cpu trap logic)
// Revision: 1.0
// ============================================================================
package leb128_fetch_pkg;

  localparam logic [3:0] LEB_ERR_NONE   = 4'd0;
  localparam logic [3:0] LEB_ERR_MEM    = 4'd1;
  localparam logic [3:0] LEB_ERR_LONG   = 4'd2;
  localparam logic [3:0] LEB_ERR_UNUSED = 4'd3;

  localparam logic [3:0] LEB_MAX_BYTES_32 = 4'd5;
  localparam logic [3:0] LEB_MAX_BYTES_64 = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_DONE   = 2'd3
  } leb_state_t;

endpackage
`default_nettype wire

// File: rtl/leb128_merge.sv
`default_nettype none
// ============================================================================
// leb128_merge : merges one LEB128 byte into the accumulator, checks the
//                unused bits of a maximum-length byte, sign-extends the result
// Revision: 1.0
// ============================================================================
module leb128_merge (
  input  logic [63:0] acc_in,
  input  logic [6:0]  shift,
  input  logic [7:0]  data_byte,
  input  logic        is_signed,
  input  logic        is_64,
  input  logic        at_max,
  output logic [63:0] acc_out,
  output logic [63:0] value_ext,
  output logic        unused_bad
);

  logic [6:0]  w_shift_next;
  logic [5:0]  w_sign_pos;
  logic [63:0] w_low_mask;

  always_comb begin
    acc_out      = acc_in | ({57'd0, data_byte[6:0]} << shift);
    w_shift_next = shift + 7'd7;

    // Sign bit is the top payload bit so far, capped at the result width.
    if (is_64) begin
      w_sign_pos = (w_shift_next >= 7'd64) ? 6'd63 : (w_shift_next[5:0] - 6'd1);
    end else begin
      w_sign_pos = (w_shift_next >= 7'd32) ? 6'd31 : (w_shift_next[5:0] - 6'd1);
    end

    w_low_mask = (w_sign_pos == 6'd63) ? {64{1'b1}} : ((64'd1 << (w_sign_pos + 6'd1)) - 64'd1);
    value_ext  = (is_signed && acc_out[w_sign_pos]) ? (acc_out | ~w_low_mask)
                                                    : (acc_out & w_low_mask);

    unused_bad = 1'b0;
    if (at_max) begin
      if (is_64) begin
        unused_bad = data_byte[6:1] != (is_signed ? {6{data_byte[0]}} : 6'd0);
      end else begin
        unused_bad = data_byte[6:4] != (is_signed ? {3{data_byte[3]}} : 3'd0);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/leb128_fetch.sv
`default_nettype none
// ============================================================================
// leb128_fetch : fetches a ULEB128/SLEB128 immediate from a byte ROM one byte
//                per FETCH/DECODE pair and reports value, length and error
// Revision: 1.0
// ============================================================================
module leb128_fetch
  import leb128_fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_DEPTH:0]        addr,
  input  logic                      is_signed,
  input  logic                      is_64,
  output logic                      busy,
  output logic                      done,
  output logic [63:0]               value,
  output logic [3:0]                length,
  output logic [3:0]                error,
  output logic [MEM_DEPTH:0]        next_addr,
  output logic [MEM_DEPTH:0]        mem_addr,
  output logic [MEM_EXTRA-1:0]      mem_extra,
  input  logic [2**MEM_EXTRA*8-1:0] mem_data,
  input  logic                      mem_error
);

  localparam int C_AW = MEM_DEPTH + 1;

  leb_state_t         r_state;
  leb_state_t         w_state_next;
  logic [MEM_DEPTH:0] r_base;
  logic [MEM_DEPTH:0] r_mem_addr;
  logic [MEM_DEPTH:0] r_next_addr;
  logic               r_signed;
  logic               r_64;
  logic [63:0]        r_acc;
  logic [63:0]        r_value;
  logic [6:0]         r_shift;
  logic [3:0]         r_count;
  logic [3:0]         r_length;
  logic [3:0]         r_error;

  logic [7:0]         w_byte;
  logic [3:0]         w_count_next;
  logic [3:0]         w_max;
  logic               w_at_max;
  logic [3:0]         w_err;
  logic               w_finish;
  logic [MEM_DEPTH:0] w_addr_next;
  logic [63:0]        w_acc_merged;
  logic [63:0]        w_value_ext;
  logic               w_unused_bad;
  logic               w_unused_hi;

  // Only the low byte of a ROM word is ever consumed.
  generate
    if (MEM_EXTRA > 0) begin : g_unused_hi
      assign w_unused_hi = ^mem_data[2**MEM_EXTRA*8-1:8];
    end else begin : g_no_hi
      assign w_unused_hi = 1'b0;
    end
  endgenerate

  assign w_byte       = mem_data[7:0];
  assign w_count_next = r_count + 4'd1;
  assign w_max        = r_64 ? LEB_MAX_BYTES_64 : LEB_MAX_BYTES_32;
  assign w_at_max     = (w_count_next == w_max);
  assign w_addr_next  = r_base + C_AW'(w_count_next);

  leb128_merge u_merge (
    .acc_in     (r_acc),
    .shift      (r_shift),
    .data_byte  (w_byte),
    .is_signed  (r_signed),
    .is_64      (r_64),
    .at_max     (w_at_max),
    .acc_out    (w_acc_merged),
    .value_ext  (w_value_ext),
    .unused_bad (w_unused_bad)
  );

  always_comb begin
    w_err = LEB_ERR_NONE;
    if (mem_error) begin
      w_err = LEB_ERR_MEM;
    end else if (w_byte[7] && w_at_max) begin
      w_err = LEB_ERR_LONG;
    end else if (!w_byte[7] && w_unused_bad) begin
      w_err = LEB_ERR_UNUSED;
    end
  end

  assign w_finish = (w_err != LEB_ERR_NONE) || !w_byte[7];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: w_state_next = w_finish ? ST_DONE : ST_FETCH;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base      <= '0;
      r_mem_addr  <= '0;
      r_next_addr <= '0;
      r_signed    <= 1'b0;
      r_64        <= 1'b0;
      r_acc       <= '0;
      r_value     <= '0;
      r_shift     <= '0;
      r_count     <= '0;
      r_length    <= '0;
      r_error     <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_base     <= addr;
        r_mem_addr <= addr;
        r_signed   <= is_signed;
        r_64       <= is_64;
        r_acc      <= '0;
        r_shift    <= '0;
        r_count    <= '0;
      end
      if (r_state == ST_DECODE) begin
        r_acc   <= w_acc_merged;
        r_shift <= r_shift + 7'd7;
        r_count <= w_count_next;
        if (w_finish) begin
          // Faulting decodes report the raw partial accumulator.
          r_value     <= (w_err == LEB_ERR_NONE) ? w_value_ext : w_acc_merged;
          r_length    <= w_count_next;
          r_error     <= w_err;
          r_next_addr <= w_addr_next;
        end else begin
          r_mem_addr <= w_addr_next;
        end
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign value     = r_value;
  assign length    = r_length;
  assign error     = r_error;
  assign next_addr = r_next_addr;
  assign mem_addr  = r_mem_addr;
  assign mem_extra = '0;

endmodule
`default_nettype wire
